biquad_coeff_loader: RTL and testbench
======================================

# biquad_coeff_loader

Wishbone-initiator sequencer that loads coefficient sets into the two-stage biquad filter chain (stage 0 at `bq_adr_o[7]=0`, stage 1 at `bq_adr_o[7]=1`, word address in `[6:2]`). On a start command it reads coefficient words from a local table, writes them one at a time with retry, timeout and abort handling, and then issues a stretched notch-update strobe together with new per-stage bypass masks. It sits between the housekeeping register space and the biquad wrapper's target port.

## Interface
- `NWORDS`, 24: coefficient words written per selected stage (1..32).
- `MAX_RTY`, 3: retries allowed per word on `rty` before abort.
- `TIMEOUT`, 255: cycles of asserted `stb` without ack/err/rty before abort.
- `UPD_LEN`, 4: `notch_update_o` high time in cycles (≥2, so the aclk-side synchronizer catches it).

Ports:
- `wb_clk_i` in 1: single clock.
- `wb_rst_i` in 1: reset, synchronous, active-high.
- `start_i` in 1: one-cycle load request; accepted only when `busy_o=0`.
- `stage_mask_i` in 2: bit s selects stage s for loading; sampled at accept.
- `byp0_i`, `byp1_i` in 6: bypass masks; sampled at accept.
- `busy_o` out 1: high from the cycle after accept through the `done_o` cycle.
- `done_o` out 1: one-cycle completion pulse.
- `err_o` out 1: high after an abort; cleared on the next accepted start.
- `tbl_rd_o` out 1: table read strobe.
- `tbl_adr_o` out 6: `{stage, idx[4:0]}`.
- `tbl_dat_i` in 32: table data, valid on the cycle after `tbl_rd_o`.
- `bq_cyc_o`, `bq_stb_o`, `bq_we_o` out 1: WB initiator controls; `we` is always 1 during a cycle.
- `bq_adr_o` out 8: `{stage, idx[4:0], 2'b00}`.
- `bq_dat_o` out 32: write data.
- `bq_sel_o` out 4: always `4'hF`.
- `bq_ack_i`, `bq_err_i`, `bq_rty_i` in 1: target responses.
- `notch_update_o` out 1: update strobe.
- `notch0_byp_o`, `notch1_byp_o` out 6: bypass masks presented to the chain.

## Operation
- States: IDLE, FETCH, LATCH, WRITE, BACKOFF, UPDATE, DONE.
- **IDLE.** When `start_i` is accepted: latch the mask and byp inputs, clear `err_o`, clear `idx` and the retry count, and set the current stage to the lowest selected stage. Go to FETCH. If the mask is 0, go straight to UPDATE.
- **FETCH.** Assert `tbl_rd_o` with `tbl_adr_o={stage,idx}`. Go to LATCH.
- **LATCH.** Capture `tbl_dat_i` into the data register. Clear the timeout counter. Go to WRITE.
- **WRITE.** Hold `cyc`, `stb`, `adr` and `dat` stable until a response. Responses are sampled with priority err > rty > ack.
  - `ack`: if `idx=NWORDS-1`, move to the next selected stage with `idx=0` and go to FETCH, or go to UPDATE if no stage remains. Otherwise increment `idx` and go to FETCH.
  - `rty`: if the retry count < `MAX_RTY`, increment it and go to BACKOFF. Otherwise abort.
  - `err`, or timeout counter reaching `TIMEOUT`: abort.
  - The retry count clears on each `ack`.
- **BACKOFF.** Deassert `cyc` and `stb` for exactly one cycle, then return to WRITE. The same word is re-presented and the timeout counter is cleared.
- **Abort.** Set `err_o` and go to DONE. UPDATE is skipped, so the byp outputs and the filter update are not applied.
- **UPDATE.** Drive `notch0_byp_o`/`notch1_byp_o` from the latched masks on the first UPDATE cycle, held thereafter. Assert `notch_update_o` for `UPD_LEN` cycles, then go to DONE.
- **DONE.** `done_o=1` for one cycle, then go to IDLE.
- `start_i` while busy is ignored, with no queueing.
- `wb_rst_i` at any point, including mid-WRITE, forces IDLE next cycle. All outputs go to 0 except `bq_sel_o`, which stays `4'hF`. `cyc` drops immediately, the in-flight word is abandoned and no update is issued.

## Timing
- All outputs are registered. Reset values are 0, except `bq_sel_o=4'hF`.
- Accept at cycle 0: first FETCH at cycle 1, LATCH at 2, `cyc`/`stb` high from cycle 3.
- An `ack` sampled in cycle t is followed by the next FETCH in cycle t+1. Each word costs 3 + W cycles, where W is the number of wait cycles before the response.
- Zero-wait, both stages, `NWORDS=24`: 48 words × 3 = 144 cycles of writes.
  - Last ack at cycle 144.
  - `notch_update_o` high on cycles 145..148.
  - `done_o` on cycle 149.
- Empty mask: `notch_update_o` high on cycles 1..`UPD_LEN`, `done_o` on cycle `UPD_LEN`+1.
- Timeout fires on the cycle in which `stb` has been asserted for `TIMEOUT` consecutive cycles without a response.

## Structure
- Package `biquad_ctrl_pkg` holds:
  - the state enum,
  - `STAGE_BIT=7`,
  - the word-index field position `[6:2]`,
  - the bypass width 6.
- Sub-module `biquad_wb_write_engine` owns the single-word WRITE/BACKOFF/retry/timeout handshake. Interface: `go`, `adr`, `dat` in; `ok`/`fail` out. The top-level FSM owns FETCH, LATCH, UPDATE and DONE.

## Test plan
- Mask `2'b11`, zero-wait ack target: 48 writes in order.
  - Addresses 0x00..0x5C, then 0x80..0xDC, with data matching the table.
  - Update high on cycles 145–148, `done_o` at 149, `err_o=0`.
- Mask `2'b10`: only stage-1 addresses (0x80..0xDC) are written.
  - `tbl_adr_o` runs 32..55.
  - byp outputs change on the first update cycle.
- Target asserts `rty` twice on word 5, then acks: two one-cycle BACKOFF gaps on that word, same address and data each time, normal completion.
- Target asserts `rty` 4 times on word 0: abort.
  - `err_o=1`, no `notch_update_o`, byp outputs unchanged, `done_o` pulses.
- Target never responds: `stb` held for 255 cycles, then abort with `err_o=1`.
  - A `start_i` during busy is ignored.
  - `wb_rst_i` asserted mid-WRITE drops `cyc` next cycle and returns all outputs to their reset values.

Source files
------------

// File: rtl/biquad_coeff_loader_pkg.sv
// Shared types and address-field layout for the biquad coefficient loader.
package biquad_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_WRITE,
        S_BACKOFF,
        S_UPDATE,
        S_DONE
    } state_e;

    localparam int STAGE_BIT = 7;
    localparam int IDX_MSB   = 6;
    localparam int IDX_LSB   = 2;
    localparam int BYP_W     = 6;

    function automatic logic [7:0] word_adr(input logic stage, input logic [4:0] idx);
        logic [7:0] a;
        a = '0;
        a[STAGE_BIT] = stage;
        a[IDX_MSB:IDX_LSB] = idx;
        return a;
    endfunction

endpackage

// File: rtl/biquad_coeff_loader_if.sv
// Wishbone write path from the loader (initiator) to the biquad wrapper (target).
interface biquad_coeff_loader_if;
    // Handshake: the initiator holds cyc/stb/adr/dat stable until it samples
    // ack, err or rty high on a clock edge with stb high (err > rty > ack).
    logic        bq_cyc_o;
    logic        bq_stb_o;
    logic        bq_we_o;
    logic [7:0]  bq_adr_o;
    logic [31:0] bq_dat_o;
    logic [3:0]  bq_sel_o;
    logic        bq_ack_i;
    logic        bq_err_i;
    logic        bq_rty_i;

    modport master (
        output bq_cyc_o, bq_stb_o, bq_we_o, bq_adr_o, bq_dat_o, bq_sel_o,
        input  bq_ack_i, bq_err_i, bq_rty_i
    );

    modport slave (
        input  bq_cyc_o, bq_stb_o, bq_we_o, bq_adr_o, bq_dat_o, bq_sel_o,
        output bq_ack_i, bq_err_i, bq_rty_i
    );
endinterface

// File: rtl/biquad_wb_write_engine.sv
// Single-word Wishbone write with retry backoff and response timeout.
module biquad_wb_write_engine
    import biquad_ctrl_pkg::*;
#(
    parameter int MAX_RTY = 3,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic [7:0]  adr,
    input  logic [31:0] dat,
    input  logic        ack,
    input  logic        err,
    input  logic        rty,
    output logic        cyc,
    output logic        stb,
    output logic [7:0]  wb_adr,
    output logic [31:0] wb_dat,
    output logic        ok,
    output logic        fail,
    output logic        retry
);
    localparam int RW = $clog2(MAX_RTY + 2);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_e          state;
    logic [RW-1:0]   rty_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic            in_write;
    logic            rty_left;
    logic            tmo_hit;

    // Responses are resolved combinationally so the caller can move on the same edge.
    always_comb begin
        in_write = (state == S_WRITE);
        rty_left = (rty_cnt < RW'(MAX_RTY));
        tmo_hit  = (tmo_cnt == TW'(TIMEOUT - 1));
        ok       = in_write && !err && !rty && ack;
        retry    = in_write && !err && rty && rty_left;
        fail     = in_write && (err || (rty && !rty_left) || (!rty && !ack && tmo_hit));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cyc     <= 1'b0;
            stb     <= 1'b0;
            wb_adr  <= '0;
            wb_dat  <= '0;
            rty_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: if (go) begin
                    state   <= S_WRITE;
                    cyc     <= 1'b1;
                    stb     <= 1'b1;
                    wb_adr  <= adr;
                    wb_dat  <= dat;
                    rty_cnt <= '0;
                    tmo_cnt <= '0;
                end
                S_WRITE: begin
                    if (ok || fail) begin
                        state <= S_IDLE;
                        cyc   <= 1'b0;
                        stb   <= 1'b0;
                        if (ok) rty_cnt <= '0;
                    end else if (retry) begin
                        state   <= S_BACKOFF;
                        cyc     <= 1'b0;
                        stb     <= 1'b0;
                        rty_cnt <= rty_cnt + 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_BACKOFF: begin
                    state   <= S_WRITE;
                    cyc     <= 1'b1;
                    stb     <= 1'b1;
                    tmo_cnt <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/biquad_coeff_loader.sv
// Sequencer that streams coefficient words from a local table into the two
// biquad stages and then applies bypass masks with a stretched update strobe.
module biquad_coeff_loader
    import biquad_ctrl_pkg::*;
#(
    parameter int NWORDS  = 24,
    parameter int MAX_RTY = 3,
    parameter int TIMEOUT = 255,
    parameter int UPD_LEN = 4
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               start_i,
    input  logic [1:0]         stage_mask_i,
    input  logic [BYP_W-1:0]   byp0_i,
    input  logic [BYP_W-1:0]   byp1_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic               tbl_rd_o,
    output logic [5:0]         tbl_adr_o,
    input  logic [31:0]        tbl_dat_i,
    biquad_coeff_loader_if.master bq,
    output logic               notch_update_o,
    output logic [BYP_W-1:0]   notch0_byp_o,
    output logic [BYP_W-1:0]   notch1_byp_o,
    output state_e             state_dbg
);
    localparam int UW = $clog2(UPD_LEN + 1);

    state_e            state;
    logic              stage;
    logic [4:0]        idx;
    logic              stage1_sel;
    logic [BYP_W-1:0]  byp0_q;
    logic [BYP_W-1:0]  byp1_q;
    logic [UW-1:0]     upd_cnt;
    logic              eng_go;
    logic [7:0]        eng_adr;
    logic              eng_ok;
    logic              eng_fail;
    logic              eng_retry;
    logic              last_word;

    assign eng_go      = (state == S_LATCH);
    assign eng_adr     = word_adr(stage, idx);
    assign last_word   = (idx == 5'(NWORDS - 1));
    assign state_dbg   = state;
    assign bq.bq_we_o  = bq.bq_cyc_o;
    assign bq.bq_sel_o = 4'hF;

    // Table data arrives during LATCH and is captured by the engine on go.
    biquad_wb_write_engine #(
        .MAX_RTY (MAX_RTY),
        .TIMEOUT (TIMEOUT)
    ) u_engine (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .go     (eng_go),
        .adr    (eng_adr),
        .dat    (tbl_dat_i),
        .ack    (bq.bq_ack_i),
        .err    (bq.bq_err_i),
        .rty    (bq.bq_rty_i),
        .cyc    (bq.bq_cyc_o),
        .stb    (bq.bq_stb_o),
        .wb_adr (bq.bq_adr_o),
        .wb_dat (bq.bq_dat_o),
        .ok     (eng_ok),
        .fail   (eng_fail),
        .retry  (eng_retry)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state          <= S_IDLE;
            stage          <= 1'b0;
            idx            <= '0;
            stage1_sel     <= 1'b0;
            byp0_q         <= '0;
            byp1_q         <= '0;
            upd_cnt        <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            err_o          <= 1'b0;
            tbl_rd_o       <= 1'b0;
            tbl_adr_o      <= '0;
            notch_update_o <= 1'b0;
            notch0_byp_o   <= '0;
            notch1_byp_o   <= '0;
        end else begin
            case (state)
                S_IDLE: if (start_i) begin
                    stage1_sel <= stage_mask_i[1];
                    byp0_q     <= byp0_i;
                    byp1_q     <= byp1_i;
                    err_o      <= 1'b0;
                    idx        <= '0;
                    busy_o     <= 1'b1;
                    stage      <= ~stage_mask_i[0];
                    if (stage_mask_i == 2'b00) begin
                        state          <= S_UPDATE;
                        notch_update_o <= 1'b1;
                        notch0_byp_o   <= byp0_i;
                        notch1_byp_o   <= byp1_i;
                        upd_cnt        <= '0;
                    end else begin
                        state     <= S_FETCH;
                        tbl_rd_o  <= 1'b1;
                        tbl_adr_o <= {~stage_mask_i[0], 5'd0};
                    end
                end
                S_FETCH: begin
                    tbl_rd_o <= 1'b0;
                    state    <= S_LATCH;
                end
                S_LATCH: state <= S_WRITE;
                S_WRITE, S_BACKOFF: begin
                    if (eng_fail) begin
                        // Abort skips UPDATE so the chain keeps its previous configuration.
                        err_o  <= 1'b1;
                        done_o <= 1'b1;
                        state  <= S_DONE;
                    end else if (eng_retry) begin
                        state <= S_BACKOFF;
                    end else if (eng_ok) begin
                        if (!last_word) begin
                            idx       <= idx + 5'd1;
                            tbl_adr_o <= {stage, idx + 5'd1};
                            tbl_rd_o  <= 1'b1;
                            state     <= S_FETCH;
                        end else if (!stage && stage1_sel) begin
                            stage     <= 1'b1;
                            idx       <= '0;
                            tbl_adr_o <= {1'b1, 5'd0};
                            tbl_rd_o  <= 1'b1;
                            state     <= S_FETCH;
                        end else begin
                            state          <= S_UPDATE;
                            notch_update_o <= 1'b1;
                            notch0_byp_o   <= byp0_q;
                            notch1_byp_o   <= byp1_q;
                            upd_cnt        <= '0;
                        end
                    end else if (state == S_BACKOFF) begin
                        state <= S_WRITE;
                    end
                end
                S_UPDATE: begin
                    if (upd_cnt == UW'(UPD_LEN - 1)) begin
                        notch_update_o <= 1'b0;
                        done_o         <= 1'b1;
                        state          <= S_DONE;
                    end else begin
                        upd_cnt <= upd_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_biquad_coeff_loader.sv
// Directed bench for biquad_coeff_loader: responder model on the WB port,
// table model, event log per run and checks against hand-derived values.
module tb_biquad_coeff_loader;
    import biquad_ctrl_pkg::*;

    localparam int M_ACK  = 0;
    localparam int M_RTY5 = 1;
    localparam int M_RTY  = 2;
    localparam int M_NONE = 3;
    localparam int M_ERR  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [1:0]  mask;
    logic [5:0]  byp0, byp1;
    logic        busy, done, err, tbl_rd, upd;
    logic [5:0]  tbl_adr, nb0, nb1;
    logic [31:0] tbl_dat;
    state_e      st;

    biquad_coeff_loader_if bq();

    biquad_coeff_loader dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .start_i        (start_i),
        .stage_mask_i   (mask),
        .byp0_i         (byp0),
        .byp1_i         (byp1),
        .busy_o         (busy),
        .done_o         (done),
        .err_o          (err),
        .tbl_rd_o       (tbl_rd),
        .tbl_adr_o      (tbl_adr),
        .tbl_dat_i      (tbl_dat),
        .bq             (bq),
        .notch_update_o (upd),
        .notch0_byp_o   (nb0),
        .notch1_byp_o   (nb1),
        .state_dbg      (st)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int mode = M_ACK;
    int unsigned cyc_n = 0;
    int unsigned t0 = 0;
    int run_id = 0;
    int seen_id = 0;
    int rel;
    int acks, rty_given, stb_cycles, upd_first, upd_last, upd_count, done_cyc, done_cnt;
    logic [5:0] byp_before0, byp_before1, byp_first0, byp_first1, nb0_prev, nb1_prev;
    logic stb_prev = 1'b0;
    logic [39:0] obs_q[$];
    logic [39:0] exp_q[$];
    logic [39:0] pres_q[$];
    int          pres_cyc_q[$];
    logic [5:0]  tbl_q[$];

    function automatic logic [31:0] tbl_word(input logic [5:0] a);
        return {8'hC0, 2'b00, a, 8'h5A, 2'b00, ~a};
    endfunction

    always @(posedge clk) cyc_n <= cyc_n + 1;
    always @(posedge clk) tbl_dat <= tbl_rd ? tbl_word(tbl_adr) : 32'hDEAD_BEEF;

    // Responder and event log, sampled on the falling edge.
    always @(negedge clk) begin
        if (run_id != seen_id) begin
            seen_id = run_id;
            obs_q.delete(); pres_q.delete(); pres_cyc_q.delete(); tbl_q.delete();
            acks = 0; rty_given = 0; stb_cycles = 0; upd_count = 0;
            upd_first = -1; upd_last = -1; done_cyc = -1; done_cnt = 0;
        end
        rel = int'(cyc_n - t0);
        bq.bq_ack_i = 1'b0;
        bq.bq_err_i = 1'b0;
        bq.bq_rty_i = 1'b0;
        if (tbl_rd) tbl_q.push_back(tbl_adr);
        if (upd) begin
            if (upd_count == 0) begin
                upd_first = rel;
                byp_before0 = nb0_prev; byp_before1 = nb1_prev;
                byp_first0 = nb0; byp_first1 = nb1;
            end
            upd_last = rel;
            upd_count++;
        end
        if (done) begin done_cyc = rel; done_cnt++; end
        if (bq.bq_cyc_o && bq.bq_stb_o) begin
            stb_cycles++;
            if (!stb_prev) begin
                pres_q.push_back({bq.bq_adr_o, bq.bq_dat_o});
                pres_cyc_q.push_back(rel);
            end
            case (mode)
                M_ACK:  bq.bq_ack_i = 1'b1;
                M_RTY5: if (acks == 5 && rty_given < 2) begin bq.bq_rty_i = 1'b1; rty_given++; end
                        else bq.bq_ack_i = 1'b1;
                M_RTY:  bq.bq_rty_i = 1'b1;
                M_ERR:  if (acks == 2) bq.bq_err_i = 1'b1; else bq.bq_ack_i = 1'b1;
                default: ;
            endcase
            if (bq.bq_ack_i) begin
                obs_q.push_back({bq.bq_adr_o, bq.bq_dat_o});
                acks++;
            end
        end
        stb_prev = bq.bq_cyc_o && bq.bq_stb_o;
        nb0_prev = nb0;
        nb1_prev = nb1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [1:0] m, input logic [5:0] b0, input logic [5:0] b1, input int md);
        @(posedge clk); #1;
        mode = md; mask = m; byp0 = b0; byp1 = b1; start_i = 1'b1;
        t0 = cyc_n;
        run_id++;
        tick(1);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int n;
        n = 0;
        while (done_cnt == 0 && n < max) begin
            tick(1);
            n++;
        end
        tick(2);
        chk("done_pulses", done_cnt, 1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ctl"}, {busy, done, err, tbl_rd, tbl_adr, upd, nb0, nb1}, 64'h0);
        chk({tag, "_bus"}, {bq.bq_cyc_o, bq.bq_stb_o, bq.bq_we_o, bq.bq_adr_o, bq.bq_dat_o, bq.bq_sel_o}, 64'hF);
        chk({tag, "_st"}, st, S_IDLE);
    endtask

    task automatic expect_stage(input int s);
        for (int i = 0; i < 24; i++)
            exp_q.push_back({8'(s * 128 + i * 4), tbl_word(6'(s * 32 + i))});
    endtask

    task automatic chk_writes();
        chk("n_writes", obs_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++)
            if (k < obs_q.size()) chk($sformatf("write%0d", k), obs_q[k], exp_q[k]);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start_i = 1'b0; mask = 2'b00; byp0 = '0; byp1 = '0;
        tick(3);
        rst = 1'b0;
        tick(1);
        chk_idle("reset");

        // Both stages, zero-wait target.
        start_run(2'b11, 6'h15, 6'h2A, M_ACK);
        chk("a_busy", busy, 1);
        wait_done(300);
        expect_stage(0);
        expect_stage(1);
        chk_writes();
        chk("a_upd_first", upd_first, 145);
        chk("a_upd_last", upd_last, 148);
        chk("a_upd_count", upd_count, 4);
        chk("a_done_cyc", done_cyc, 149);
        chk("a_err", err, 0);
        chk("a_busy_end", busy, 0);
        chk("a_byp_before", {byp_before0, byp_before1}, 12'h000);
        chk("a_byp_first", {byp_first0, byp_first1}, {6'h15, 6'h2A});

        // Stage 1 only.
        start_run(2'b10, 6'h07, 6'h38, M_ACK);
        wait_done(300);
        chk("b_tbl_n", tbl_q.size(), 24);
        for (int k = 0; k < 24; k++)
            if (k < tbl_q.size()) chk($sformatf("b_tbl%0d", k), tbl_q[k], 32 + k);
        expect_stage(1);
        chk_writes();
        chk("b_upd_first", upd_first, 73);
        chk("b_done_cyc", done_cyc, 77);
        chk("b_byp_before", {byp_before0, byp_before1}, {6'h15, 6'h2A});
        chk("b_byp_first", {byp_first0, byp_first1}, {6'h07, 6'h38});

        // Two retries on word 5, then ack.
        start_run(2'b01, 6'h01, 6'h02, M_RTY5);
        wait_done(300);
        expect_stage(0);
        chk_writes();
        chk("c_pres_n", pres_q.size(), 26);
        for (int k = 5; k < 8; k++) begin
            chk($sformatf("c_pres%0d", k), pres_q[k], {8'h14, tbl_word(6'd5)});
            chk($sformatf("c_pcyc%0d", k), pres_cyc_q[k], 18 + 2 * (k - 5));
        end
        chk("c_done_cyc", done_cyc, 81);
        chk("c_err", err, 0);
        chk("c_byp", {nb0, nb1}, {6'h01, 6'h02});

        // Error response on word 2.
        start_run(2'b01, 6'h3F, 6'h3F, M_ERR);
        wait_done(300);
        chk("e_writes", obs_q.size(), 2);
        chk("e_done_cyc", done_cyc, 10);
        chk("e_err", err, 1);
        chk("e_upd", upd_count, 0);

        // Retry exhaustion on word 0.
        start_run(2'b11, 6'h3F, 6'h3F, M_RTY);
        chk("d_err_clr", err, 0);
        wait_done(300);
        chk("d_pres_n", pres_q.size(), 4);
        chk("d_pcyc3", pres_cyc_q[3], 9);
        chk("d_done_cyc", done_cyc, 10);
        chk("d_err", err, 1);
        chk("d_upd", upd_count, 0);
        chk("d_writes", obs_q.size(), 0);
        chk("d_byp_kept", {nb0, nb1}, {6'h01, 6'h02});
        chk("d_busy_end", busy, 0);

        // Silent target: timeout, and a start while busy is ignored.
        start_run(2'b01, 6'h0F, 6'h0F, M_NONE);
        tick(48);
        chk("f_busy", busy, 1);
        mask = 2'b00; start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
        wait_done(400);
        chk("f_stb_cycles", stb_cycles, 255);
        chk("f_pres_n", pres_q.size(), 1);
        chk("f_done_cyc", done_cyc, 258);
        chk("f_err", err, 1);
        chk("f_upd", upd_count, 0);

        // Reset in the middle of a write.
        start_run(2'b01, 6'h11, 6'h22, M_NONE);
        chk("g_err_clr", err, 0);
        tick(5);
        chk("g_cyc_before", bq.bq_cyc_o, 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk_idle("g_reset");
        tick(10);
        chk("g_upd", upd_count, 0);
        chk("g_done", done_cnt, 0);

        // Empty mask goes straight to the update.
        start_run(2'b00, 6'h2A, 6'h15, M_ACK);
        wait_done(50);
        chk("h_upd_first", upd_first, 1);
        chk("h_upd_last", upd_last, 4);
        chk("h_done_cyc", done_cyc, 5);
        chk("h_tbl_n", tbl_q.size(), 0);
        chk("h_byp", {nb0, nb1}, {6'h2A, 6'h15});
        chk("h_err", err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
